// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (signed DIV / unsigned DIVU) returning {remainder, quotient}.
// Latency: start accepted in IDLE, WIDTH BUSY cycles, result presented in the following DONE cycle.
// Backpressure: stall_req freezes the pipeline while working; hold keeps DONE/ready asserted.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   en, alucontrol   execute-stage valid and decoded ALU op; DIV/DIVU start a division
//   a, b             dividend / divisor, sampled only on the start edge
//   cancel           pipeline flush; aborts BUSY/DONE and blocks a start
//   hold             downstream stall; keeps a finished result presented
//   result           {hi = remainder, lo = quotient}, registered
//   ready            result valid this cycle (DONE)
//   stall_req        combinational freeze request for IF..EX
module div_radix2 #(
  parameter int         WIDTH        = 32,
  parameter logic [4:0] DIV_CONTROL  = 5'b11010,
  parameter logic [4:0] DIVU_CONTROL = 5'b11011
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en,
  input  logic [4:0]         alucontrol,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  input  logic               hold,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d;   // negate quotient at the end
  logic               rneg_q, rneg_d;   // negate remainder at the end
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               is_div;
  logic               start;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     upper;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  always_comb begin
    is_div = (alucontrol == DIV_CONTROL);
    start  = en && !cancel && (is_div || (alucontrol == DIVU_CONTROL));

    // Magnitudes are plain unsigned WIDTH-bit values, so the most negative
    // number keeps its own bit pattern and the overflow case wraps naturally.
    abs_a = (is_div && a[WIDTH-1]) ? (~a + ONE_W) : a;
    abs_b = (is_div && b[WIDTH-1]) ? (~b + ONE_W) : b;

    // One restoring step: bring the next dividend bit into the remainder and
    // trial-subtract. The comparison uses WIDTH+1 bits so the carried-out bit
    // counts; the kept difference always fits back into WIDTH bits.
    upper  = {rem_q, quo_q[WIDTH-1]};
    ge     = (upper >= {1'b0, dvs_q});
    rem_nx = ge ? (upper[WIDTH-1:0] - dvs_q) : upper[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ge};

    quo_fix = qneg_q ? (~quo_nx + ONE_W) : quo_nx;
    rem_fix = rneg_q ? (~rem_nx + ONE_W) : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          cnt_d   = '0;
          qneg_d  = is_div && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = is_div && a[WIDTH-1];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + ONE_CW;
          if (cnt_q == LAST) begin
            result_d = {rem_fix, quo_fix};
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (cancel || !hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign ready     = (state_q == S_DONE);
  assign stall_req = ((state_q == S_IDLE) && start) || (state_q == S_BUSY);

endmodule

// File: doc/div_radix2.md
# div_radix2

Multi-cycle radix-2 restoring divider in the execute stage, directly downstream of the ALU control decoder. Starts when the decoded `alucontrol` is `DIV_CONTROL` or `DIVU_CONTROL` and the execute-stage instruction is valid. Stalls the pipeline for the duration and returns `{remainder, quotient}` for the HI/LO write.

## Interface
- `WIDTH`, default 32: operand width. The result is `2*WIDTH` bits.
- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: reset. Synchronous and active-low.
- `en`  in  1: execute-stage instruction is valid (not a bubble).
- `alucontrol`  in  5: decoded ALU operation. Only the `DIV_CONTROL` and `DIVU_CONTROL` codes from `defines2.vh` are acted on.
- `a`  in  WIDTH: dividend (rs).
- `b`  in  WIDTH: divisor (rt).
- `cancel`  in  1: pipeline flush (exception/eret). Aborts any division in progress.
- `hold`  in  1: downstream stall. Keeps a finished result presented.
- `result`  out  2*WIDTH: `{hi = remainder, lo = quotient}`. Registered.
- `ready`  out  1: `result` is valid this cycle.
- `stall_req`  out  1: combinational request to freeze IF through EX.

## Operation
- States are IDLE, BUSY and DONE. Reset puts the block in IDLE with `result`=0, `ready`=0 and the iteration counter at 0.
- The start condition is `en && !cancel && (alucontrol==DIV_CONTROL || alucontrol==DIVU_CONTROL)`, evaluated only in IDLE.
- **IDLE, start condition true:**
  - latch |a| and |b| (absolute values only when signed; the raw values when unsigned);
  - latch the quotient sign `a[W-1]^b[W-1]` and the remainder sign `a[W-1]`, both only when signed;
  - clear the partial remainder and the counter;
  - go to BUSY.
- **BUSY, one iteration per cycle:**
  - shift `{rem, quo}` left by 1;
  - trial-subtract the divisor from the upper WIDTH+1 bits;
  - if the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0;
  - counter +1; after iteration WIDTH (counter == WIDTH-1), go to DONE.
- **Sign fix on the final iteration, signed only:** negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set.
- **Writing `result`:** it is loaded on the BUSY→DONE edge and holds its value until the next BUSY→DONE edge.
- **DONE:**
  - `ready`=1;
  - with `hold`=1, stay in DONE and keep `ready` high;
  - with `hold`=0, go to IDLE next cycle, and `ready` drops.
- **`cancel`:**
  - in BUSY or DONE, go to IDLE next cycle and drop `ready`; `result` is not updated by an aborted division;
  - takes priority over a start in the same cycle;
  - in IDLE, suppresses the start.
- **`stall_req`** = `(IDLE && start condition) || BUSY`. It is 0 in DONE, so the instruction advances in the first DONE cycle unless `hold` is set.
- **Arithmetic corner cases:**
  - `0x80000000 / -1` (signed): magnitudes are treated as unsigned WIDTH-bit values, so the quotient wraps to `0x80000000` and the remainder is 0;
  - divide by zero raises no exception, and the result follows the algorithm: unsigned quotient all-ones, remainder = dividend magnitude, then the signed fix is applied.
- **`resetn` low in any state:** IDLE next edge, outputs return to their reset values.

## Timing
- Start accepted in cycle T (IDLE, `stall_req`=1).
- BUSY in T+1 … T+WIDTH (`stall_req`=1).
- DONE in T+WIDTH+1, with `ready`=1 and `result` valid.
- Total pipeline freeze is WIDTH+1 cycles (33 at WIDTH=32).
- The earliest next start is T+WIDTH+2, i.e. the first IDLE cycle after DONE.
- Operands are sampled only at the start edge; later changes on `a`/`b` have no effect.

## Test plan
- **DIVU 100/7:** `alucontrol=DIVU_CONTROL`, `en`=1, a=100, b=7 at T → `stall_req` is 1 for T…T+32; at T+33 `ready`=1, lo=14, hi=2.
- **DIV sign handling:**
  - a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- **Signed overflow and divide by zero:**
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0;
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
- **Cancel mid-division:** start at T, `cancel`=1 at T+10 → IDLE at T+11, `ready` never asserts, `result` unchanged. A new DIVU 9/3 at T+12 gives lo=3, hi=0 at T+45.
- **Hold in DONE:** `hold`=1 for 3 cycles starting in the DONE cycle → `ready` stays high with a stable `result` for 3 cycles; IDLE one cycle after `hold` drops.
- **Non-divide opcodes:** `alucontrol=ADD_CONTROL` or `MULT_CONTROL` with `en`=1, and DIV with `en`=0 → state stays IDLE, `stall_req`=0, `ready`=0. Synchronous reset pulsed during BUSY → `ready`=0 and `result`=0 after the edge.
